// File: rtl/source_sel_ctrl_if.sv
// Button/LED/mux-select bundle between the board and the source selector controller.
// master = the controller, slave = board buttons, LEDs and source mux.
interface source_sel_ctrl_if;
   logic [1:0] pb_n;
   logic       auto_en;
   logic [1:0] sel;
   logic [1:0] indic;
   logic       switching;

   modport master (
      input  pb_n,
      input  auto_en,
      output sel,
      output indic,
      output switching
   );

   modport slave (
      output pb_n,
      output auto_en,
      input  sel,
      input  indic,
      input  switching
   );
endinterface

// File: rtl/source_sel_ctrl.sv
// Test-source selector: synchronizes/debounces PB0/PB1, steps the 4:1 mux select, drives LEDs.
// Optional auto-scan dwell timer is built only when SOURCE_SEL_AUTO_EN is defined.
module source_sel_ctrl #(
   parameter int unsigned DEBOUNCE_CYC = 16,
   parameter int unsigned DWELL_CYC    = 1024,
   parameter int unsigned SETTLE_CYC   = 8
) (
   input  logic              clk1280,
   input  logic              rst,
   source_sel_ctrl_if.master bus
);

   localparam int unsigned DB_W = $clog2(DEBOUNCE_CYC);
   localparam int unsigned ST_W = $clog2(SETTLE_CYC + 1);

   typedef enum logic {
      IDLE   = 1'b0,
      SETTLE = 1'b1
   } state_t;

   state_t          state;
   logic [1:0]      sync1;
   logic [1:0]      sync2;
   logic [1:0]      db;
   logic [1:0]      db_prev;
   logic [1:0]      press;
   logic [DB_W-1:0] db_cnt [2];
   logic [1:0]      sel_q;
   logic [1:0]      indic_q;
   logic            switching_q;
   logic [ST_W-1:0] settle_cnt;
   logic [1:0]      next_sel_c;
   logic            auto_adv_c;
   logic            update_c;

   // Two-flop synchronizer, debounce and registered press pulse (falling debounced level).
   always_ff @(posedge clk1280) begin
      if (rst) begin
         sync1   <= 2'b11;
         sync2   <= 2'b11;
         db      <= 2'b11;
         db_prev <= 2'b11;
         press   <= 2'b00;
         for (int i = 0; i < 2; i++) begin
            db_cnt[i] <= '0;
         end
      end else begin
         sync1   <= bus.pb_n;
         sync2   <= sync1;
         db_prev <= db;
         press   <= db_prev & ~db;
         for (int i = 0; i < 2; i++) begin
            if (sync2[i] == db[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYC - 1)) begin
               db[i]     <= sync2[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + DB_W'(1);
            end
         end
      end
   end

`ifdef SOURCE_SEL_AUTO_EN
   localparam int unsigned DW_W = $clog2(DWELL_CYC);

   logic [DW_W-1:0] dwell_cnt;

   // Manual presses win over an auto advance landing on the same cycle.
   assign auto_adv_c = (state == IDLE) && bus.auto_en && (press == 2'b00) &&
                       (dwell_cnt == DW_W'(DWELL_CYC - 1));

   always_ff @(posedge clk1280) begin
      if (rst) begin
         dwell_cnt <= '0;
      end else if ((state != IDLE) || !bus.auto_en || (press != 2'b00) || auto_adv_c) begin
         dwell_cnt <= '0;
      end else begin
         dwell_cnt <= dwell_cnt + DW_W'(1);
      end
   end
`else
   assign auto_adv_c = 1'b0;
`endif

   assign update_c = (state == IDLE) && ((press != 2'b00) || auto_adv_c);

   // Next select: both buttons home to ch1, PB0 steps up, PB1 steps down, auto steps up.
   always_comb begin
      next_sel_c = sel_q;
      case (press)
         2'b11:   next_sel_c = 2'b00;
         2'b01:   next_sel_c = sel_q + 2'd1;
         2'b10:   next_sel_c = sel_q - 2'd1;
         default: begin
            if (auto_adv_c) begin
               next_sel_c = sel_q + 2'd1;
            end
         end
      endcase
   end

   // Select FSM; presses seen while settling are dropped.
   always_ff @(posedge clk1280) begin
      if (rst) begin
         state       <= IDLE;
         sel_q       <= 2'b00;
         indic_q     <= 2'b00;
         switching_q <= 1'b0;
         settle_cnt  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (update_c) begin
                  sel_q       <= next_sel_c;
                  indic_q     <= next_sel_c;
                  switching_q <= 1'b1;
                  settle_cnt  <= '0;
                  state       <= SETTLE;
               end
            end
            SETTLE: begin
               if (settle_cnt == ST_W'(SETTLE_CYC - 1)) begin
                  switching_q <= 1'b0;
                  state       <= IDLE;
               end else begin
                  settle_cnt <= settle_cnt + ST_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.sel       = sel_q;
   assign bus.indic     = indic_q;
   assign bus.switching = switching_q;

endmodule

// File: tb/tb_source_sel_ctrl.sv
// Self-checking bench for source_sel_ctrl: directed scenarios plus random button traffic
// compared against a behavioural model of the selector rules.
module tb_source_sel_ctrl;

   localparam int unsigned DEB    = 4;
   localparam int unsigned DWELL  = 20;
   localparam int unsigned SETTLE = 8;

   logic       clk1280 = 1'b0;
   logic       rst     = 1'b1;
   logic [1:0] pb_n    = 2'b11;
   logic       auto_en = 1'b0;

   int checks = 0;
   int errors = 0;

   always #5 clk1280 = ~clk1280;

   source_sel_ctrl_if bus ();
   assign bus.pb_n    = pb_n;
   assign bus.auto_en = auto_en;

   source_sel_ctrl #(
      .DEBOUNCE_CYC(DEB),
      .DWELL_CYC   (DWELL),
      .SETTLE_CYC  (SETTLE)
   ) dut (
      .clk1280(clk1280),
      .rst    (rst),
      .bus    (bus)
   );

   // Behavioural model: raw level seen two cycles late, accepted after DEB differing samples,
   // press acted on two cycles after acceptance; settle_left counts remaining busy cycles.
   int m_s1[2], m_s2[2], m_db[2], m_run[2], m_ev0[2], m_ev1[2];
   int m_sel, m_left, m_dwell;

   function automatic void model_reset();
      for (int b = 0; b < 2; b++) begin
         m_s1[b] = 1; m_s2[b] = 1; m_db[b] = 1; m_run[b] = 0; m_ev0[b] = 0; m_ev1[b] = 0;
      end
      m_sel = 0; m_left = 0; m_dwell = 0;
   endfunction

   function automatic void model_step();
      int act[2];
      int auto_ok;
      if (rst) begin
         model_reset();
         return;
      end
      for (int b = 0; b < 2; b++) begin
         act[b]   = m_ev1[b];
         m_ev1[b] = m_ev0[b];
         m_ev0[b] = 0;
         m_run[b] = (m_s2[b] != m_db[b]) ? m_run[b] + 1 : 0;
         if (m_run[b] == int'(DEB)) begin
            m_db[b]  = m_s2[b];
            m_run[b] = 0;
            m_ev0[b] = (m_db[b] == 0) ? 1 : 0;
         end
         m_s2[b] = m_s1[b];
         m_s1[b] = int'(pb_n[b]);
      end
`ifdef SOURCE_SEL_AUTO_EN
      auto_ok = (auto_en && m_dwell == int'(DWELL) - 1) ? 1 : 0;
`else
      auto_ok = 0;
`endif
      if (m_left > 0) begin
         m_left  = m_left - 1;
         m_dwell = 0;
      end else if (act[0] != 0 || act[1] != 0 || auto_ok != 0) begin
         if (act[0] != 0 && act[1] != 0) m_sel = 0;
         else if (act[0] != 0)           m_sel = (m_sel + 1) % 4;
         else if (act[1] != 0)           m_sel = (m_sel + 3) % 4;
         else                            m_sel = (m_sel + 1) % 4;
         m_left  = int'(SETTLE);
         m_dwell = 0;
      end else begin
         m_dwell = auto_en ? m_dwell + 1 : 0;
      end
   endfunction

   task automatic tick();
      @(posedge clk1280);
      model_step();
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      pb_n = 2'b11; auto_en = 1'b0;
      do_reset();
      checks++;
      if (bus.sel !== 2'b00 || bus.indic !== 2'b00 || bus.switching !== 1'b0) begin
         errors++;
         $display("FAIL reset: sel=%b indic=%b sw=%b, required 00 00 0", bus.sel, bus.indic, bus.switching);
      end
   endtask

   // PB0 first sampled low at tick 0: sel 01 at tick 3+DEB, switching for SETTLE ticks.
   task automatic test_single_press();
      logic [1:0] exp_sel;
      logic       exp_sw;
      do_reset();
      pb_n = 2'b10;
      for (int n = 0; n < 40; n++) begin
         if (n == 20) pb_n = 2'b11;
         tick();
         exp_sel = (n >= 3 + int'(DEB)) ? 2'b01 : 2'b00;
         exp_sw  = (n >= 3 + int'(DEB)) && (n < 3 + int'(DEB) + int'(SETTLE));
         checks++;
         if (bus.sel !== exp_sel || bus.indic !== exp_sel || bus.switching !== exp_sw) begin
            errors++;
            $display("FAIL single_press tick %0d: sel=%b indic=%b sw=%b, required %b %b %b",
                     n, bus.sel, bus.indic, bus.switching, exp_sel, exp_sel, exp_sw);
         end
      end
   endtask

   task automatic test_glitch();
      do_reset();
      for (int r = 0; r < 2; r++) begin
         for (int n = 0; n < 10; n++) begin
            pb_n = (n < int'(DEB) - 1) ? 2'b10 : 2'b11;
            tick();
            checks++;
            if (bus.sel !== 2'b00 || bus.switching !== 1'b0) begin
               errors++;
               $display("FAIL glitch rep %0d tick %0d: sel=%b sw=%b, required 00 0",
                        r, n, bus.sel, bus.switching);
            end
         end
      end
   endtask

   task automatic test_wrap();
      logic [1:0] exp_sel;
      pb_n = 2'b01;
      for (int n = 0; n < 25; n++) begin
         if (n == 10) pb_n = 2'b11;
         tick();
      end
      checks++;
      if (bus.sel !== 2'b11 || bus.indic !== 2'b11) begin
         errors++;
         $display("FAIL wrap_down: sel=%b indic=%b, required 11", bus.sel, bus.indic);
      end
      for (int p = 0; p < 4; p++) begin
         for (int n = 0; n < 20; n++) begin
            pb_n = (n < 8) ? 2'b10 : 2'b11;
            tick();
         end
         exp_sel = 2'(p);
         checks++;
         if (bus.sel !== exp_sel || bus.indic !== exp_sel || bus.switching !== 1'b0) begin
            errors++;
            $display("FAIL wrap_up press %0d: sel=%b indic=%b sw=%b, required %b %b 0",
                     p, bus.sel, bus.indic, bus.switching, exp_sel, exp_sel);
         end
      end
   endtask

   // Both buttons together home the select; a PB0 press whose pulse lands in SETTLE is lost.
   task automatic test_both_and_drop();
      do_reset();
      for (int p = 0; p < 2; p++) begin
         for (int n = 0; n < 20; n++) begin
            pb_n = (n < 8) ? 2'b10 : 2'b11;
            tick();
         end
      end
      checks++;
      if (bus.sel !== 2'b10) begin
         errors++;
         $display("FAIL both_setup: sel=%b, required 10", bus.sel);
      end
      for (int n = 0; n < 40; n++) begin
         if (n < 4)       pb_n = 2'b00;
         else if (n < 8)  pb_n = 2'b11;
         else if (n < 20) pb_n = 2'b10;
         else             pb_n = 2'b11;
         tick();
         if (n == 3 + int'(DEB)) begin
            checks++;
            if (bus.sel !== 2'b00 || bus.switching !== 1'b1) begin
               errors++;
               $display("FAIL both_press: sel=%b sw=%b, required 00 1", bus.sel, bus.switching);
            end
         end
      end
      checks++;
      if (bus.sel !== 2'b00 || bus.indic !== 2'b00 || bus.switching !== 1'b0) begin
         errors++;
         $display("FAIL drop_in_settle: sel=%b indic=%b sw=%b, required 00 00 0",
                  bus.sel, bus.indic, bus.switching);
      end
   endtask

   task automatic test_auto();
      logic [1:0] exp_sel;
      int         adv;
      auto_en = 1'b1;
      pb_n    = 2'b11;
      do_reset();
      for (int n = 1; n <= 120; n++) begin
         tick();
`ifdef SOURCE_SEL_AUTO_EN
         adv = 0;
         for (int i = 0; i < 5; i++) begin
            if (n >= int'(DWELL) + i * int'(DWELL + SETTLE)) adv++;
         end
`else
         adv = 0;
`endif
         exp_sel = 2'(adv % 4);
         checks++;
         if (bus.sel !== exp_sel || bus.indic !== exp_sel) begin
            errors++;
            $display("FAIL auto tick %0d: sel=%b indic=%b, required %b", n, bus.sel, bus.indic, exp_sel);
         end
      end
      auto_en = 1'b0;
      exp_sel = bus.sel;
      for (int n = 0; n < 80; n++) tick();
      checks++;
`ifdef SOURCE_SEL_AUTO_EN
      if (bus.sel !== 2'b00) begin
`else
      if (bus.sel !== 2'b00 || exp_sel !== 2'b00) begin
`endif
         errors++;
         $display("FAIL auto_freeze: sel=%b, required 00", bus.sel);
      end
   endtask

   task automatic test_reset_mid_settle();
      do_reset();
      for (int n = 0; n < 20; n++) begin
         pb_n = (n < 8) ? 2'b10 : 2'b11;
         tick();
      end
      pb_n = 2'b10;
      for (int n = 0; n < 9; n++) tick();
      checks++;
      if (bus.sel !== 2'b10 || bus.switching !== 1'b1) begin
         errors++;
         $display("FAIL rst_setup: sel=%b sw=%b, required 10 1", bus.sel, bus.switching);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (bus.sel !== 2'b00 || bus.indic !== 2'b00 || bus.switching !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_settle: sel=%b indic=%b sw=%b, required 00 00 0",
                  bus.sel, bus.indic, bus.switching);
      end
      for (int n = 0; n < 40; n++) tick();
      checks++;
      if (bus.sel !== 2'b01 || bus.switching !== 1'b0) begin
         errors++;
         $display("FAIL held_after_rst: sel=%b sw=%b, required 01 0", bus.sel, bus.switching);
      end
      pb_n = 2'b11;
      for (int n = 0; n < 10; n++) tick();
   endtask

   task automatic test_random();
      int hold;
      hold = 0;
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         if (hold == 0) begin
            pb_n = 2'($urandom_range(0, 3));
            hold = $urandom_range(1, 12);
         end
         hold--;
         if ($urandom_range(0, 199) == 0) auto_en = ~auto_en;
         rst = ($urandom_range(0, 499) == 0);
         tick();
         checks++;
         if (bus.sel !== 2'(m_sel) || bus.indic !== 2'(m_sel) || bus.switching !== (m_left > 0)) begin
            errors++;
            $display("FAIL random tick %0d: sel=%b indic=%b sw=%b, required %b %b %b",
                     n, bus.sel, bus.indic, bus.switching, 2'(m_sel), 2'(m_sel), (m_left > 0));
         end
      end
      rst = 1'b0;
   endtask

   // Directed scenarios are also cross-checked against the model every cycle.
   always @(negedge clk1280) begin
      if (!rst) begin
         checks++;
         if (bus.sel !== 2'(m_sel) || bus.switching !== (m_left > 0)) begin
            errors++;
            $display("FAIL model t=%0t: sel=%b sw=%b, required %b %b",
                     $time, bus.sel, bus.switching, 2'(m_sel), (m_left > 0));
         end
      end
   end

   initial begin
      model_reset();
      test_reset();
      test_single_press();
      test_glitch();
      test_wrap();
      test_both_and_drop();
      test_auto();
      test_reset_mid_settle();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
